seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised multiplexed seven-segment driver for the board's 8-digit common-anode display, replacing the fixed 8-bit binary-only scanner. It accepts a value with a load handshake and displays it in binary-per-digit, hexadecimal or decimal. Decimal uses a sequential binary-to-BCD converter. It has an internal refresh prescaler in place of a derived clock, leading-zero blanking, per-digit decimal points and tear-free double buffering. It sits between the counter/datapath logic and the AN/CA..CG/DP pins in the top-level display module.

## Interface
- DIGITS, 8: number of digits scanned, 1..8.
- VAL_W, 32: width of the input value, 1..32.
- CLK_HZ, 100_000_000: frequency of CLK in Hz.
- SCAN_HZ, 1000: digit-advance rate in Hz; CLK_HZ/SCAN_HZ must be ≥ 2.

- CLK  in  1  system clock; the sole clock.
- RST  in  1  synchronous reset, active-high.
- value  in  VAL_W  number to display.
- mode  in  2  00 binary (digit i shows value[i]), 01 hex, 10 decimal, 11 blank.
- lz_blank  in  1  1 = suppress leading zeros (hex and decimal only).
- dp  in  DIGITS  dp[i]=1 lights the decimal point on digit i.
- load  in  1  request to capture value, mode, lz_blank and dp.
- busy  out  1  decimal conversion in progress; load is ignored while high.
- AN  out  DIGITS  digit enables, active-low, one-hot-low.
- SEG  out  7  segments a..g on bits 0..6, active-low.
- DP  out  1  decimal point, active-low.

## Operation
- Capture: a load is accepted when load=1 and busy=0. The capture registers sample value, mode, lz_blank and dp. load while busy=1 is dropped with no side effect.
- Binary, hex and blank modes: the display buffer (digits, dp, mode, lz_blank) is written on the edge after acceptance. busy stays 0.
- Binary mode: digit i shows 0 or 1 from value[i]; digits i ≥ VAL_W show 0. lz_blank is ignored.
- Hex mode: digit i shows value[4i+3:4i], zero-extended. Glyphs 0-9 and A, b, C, d, E, F.
- Decimal mode: busy=1 for exactly VAL_W cycles while a shift-add-3 double-dabble runs, one input bit per cycle, into a 4*DIGITS BCD register.
  - Overflow is sticky during the conversion. It is set if any 1 shifts out of the top BCD digit, i.e. value ≥ 10^DIGITS.
  - On completion the buffer is written and busy falls. On overflow every digit shows dash (segment g only) and the dp bits still apply.
- Leading-zero blanking (hex/decimal, lz_blank=1): digits above the most-significant nonzero digit have their AN held high. Digit 0 is always shown, so value 0 shows a single "0".
- Blank mode: AN stays all-ones and scanning continues internally.
- Scan:
  - The prescaler counts 0..CLK_HZ/SCAN_HZ-1 and emits a 1-cycle tick at the terminal count.
  - Each tick advances the digit index 0→1→…→DIGITS-1→0.
  - On the tick edge, AN, SEG and DP are registered together from the new index and the current buffer.
- Buffer/tick coincidence: if the buffer write and a tick land on the same edge, the outputs use the old buffer. The new contents appear from the next tick. There is no partial-digit tearing.

## Timing
- Reset (RST=1 at an edge) sets:
  - outputs: AN all ones, SEG 7'h7F, DP=1, busy=0;
  - scan state: prescaler 0, digit index 0;
  - buffer: mode=hex, lz_blank=0, dp=0, all digits 0.
- After reset the first tick, at cycle CLK_HZ/SCAN_HZ, drives digit 0 with glyph "0".
- RST during a conversion aborts it: busy=0 on the next cycle and the buffer takes its reset value.
- RST has priority over load on the same edge.
- Load latency:
  - binary/hex/blank: buffer valid 1 cycle after acceptance;
  - decimal: busy high for cycles t+1..t+VAL_W, buffer valid and busy=0 at t+VAL_W+1.
- A new load is accepted in the same cycle busy falls.
- Output latency from a tick edge to new AN/SEG/DP: 0 cycles, since they are registered on that edge.
- Full refresh period: DIGITS ticks.

## Test plan
- Reset, CLK_HZ=100, SCAN_HZ=25 (tick every 4 cycles), DIGITS=8:
  - AN=8'hFF and SEG=7'h7F until cycle 4;
  - then AN=8'hFE, SEG=7'h40 ("0");
  - AN walks FD, FB, …, 7F and wraps to FE.
- Hex load value=32'h0000_A5C3, lz_blank=1:
  - digits 0..3 show 3 (SEG 7'h30), C (7'h46), 5 (7'h12), A (7'h08);
  - AN never goes low for digits 4..7;
  - busy never rises.
- Decimal load value=12345, VAL_W=32, DIGITS=8, lz_blank=0:
  - busy high exactly 32 cycles;
  - the display then reads 00012345;
  - a second load issued mid-conversion is ignored and the result is unchanged.
- Decimal load value=100_000_000 (≥10^8): all digits show dash (SEG 7'h3F); dp=8'h01 also drives DP=0 on digit 0 only.
- Binary mode with value=8'b1011_0010, DIGITS=8: digits 7..0 show 1,0,1,1,0,0,1,0.
- Edge cases:
  - assert RST at conversion cycle 10: busy=0 next cycle and the display returns to all zeros from the next tick;
  - load hex coincident with a tick: the old glyph is shown for that tick and the new glyph from the next tick.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed common-anode seven-segment scanner.
// Captures a value on a load handshake, converts it (binary / hex / decimal
// via sequential double-dabble) into a double-buffered digit store, and
// scans the digits at a prescaled refresh rate with leading-zero blanking
// and per-digit decimal points.
module seg_scan_driver #(
  parameter int DIGITS  = 8,
  parameter int VAL_W   = 32,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [VAL_W-1:0]  value,
  input  logic [1:0]        mode,
  input  logic              lz_blank,
  input  logic [DIGITS-1:0] dp,
  input  logic              load,
  output logic              busy,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        SEG,
  output logic              DP
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW  = 4 * DIGITS;
  localparam int SW  = $clog2(VAL_W + 1);

  localparam logic [1:0] MODE_BIN   = 2'b00;
  localparam logic [1:0] MODE_HEX   = 2'b01;
  localparam logic [1:0] MODE_DEC   = 2'b10;
  localparam logic [1:0] MODE_BLANK = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CONV  = 2'd2
  } state_t;

  // Active-low glyphs, segment a on bit 0 through g on bit 6.
  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------- scan
  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [IW-1:0] r_idx;

  assign w_tick = (r_presc == PW'(DIV - 1));

  // Refresh prescaler: free-running 0..DIV-1, tick at terminal count.
  always_ff @(posedge CLK) begin
    if (RST)         r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // Index of the digit to be driven at the next tick.
  always_ff @(posedge CLK) begin
    if (RST)
      r_idx <= '0;
    else if (w_tick)
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
  end

  // ------------------------------------------------------ control FSM
  state_t r_state, w_state_next;
  logic   w_accept;
  logic   w_buf_we;
  logic   w_last;
  logic [SW-1:0] r_step;

  assign busy     = (r_state == S_CONV);
  assign w_accept = load & ~busy;
  assign w_last   = (r_state == S_CONV) && (r_step == SW'(VAL_W - 1));

  // Control state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and buffer write strobe; a load is taken whenever not converting.
  always_comb begin
    w_state_next = r_state;
    w_buf_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = (mode == MODE_DEC) ? S_CONV : S_WRITE;
      end
      S_WRITE: begin
        w_buf_we = 1'b1;
        if (w_accept) w_state_next = (mode == MODE_DEC) ? S_CONV : S_WRITE;
        else          w_state_next = S_IDLE;
      end
      S_CONV: begin
        if (w_last) begin
          w_buf_we     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------- capture registers
  logic [VAL_W-1:0]  r_cap_value;
  logic [1:0]        r_cap_mode;
  logic              r_cap_lz;
  logic [DIGITS-1:0] r_cap_dp;

  // Sample the request fields on every accepted load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cap_value <= '0;
      r_cap_mode  <= MODE_HEX;
      r_cap_lz    <= 1'b0;
      r_cap_dp    <= '0;
    end else if (w_accept) begin
      r_cap_value <= value;
      r_cap_mode  <= mode;
      r_cap_lz    <= lz_blank;
      r_cap_dp    <= dp;
    end
  end

  // ------------------------------------------------- double-dabble core
  logic [VAL_W-1:0] r_sh;
  logic [BW-1:0]    r_bcd;
  logic             r_ovf;
  logic [BW-1:0]    w_bcd_adj;
  logic [BW-1:0]    w_bcd_next;
  logic             w_ovf_next;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                  r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
  end

  // A 1 leaving the top digit means the value does not fit in DIGITS digits.
  assign w_bcd_next = {w_bcd_adj[BW-2:0], r_sh[VAL_W-1]};
  assign w_ovf_next = r_ovf | w_bcd_adj[BW-1];

  // One input bit per cycle, MSB first, while converting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sh   <= '0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_step <= '0;
    end else if (w_accept && (mode == MODE_DEC)) begin
      r_sh   <= value;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_step <= '0;
    end else if (r_state == S_CONV) begin
      r_sh   <= r_sh << 1;
      r_bcd  <= w_bcd_next;
      r_ovf  <= w_ovf_next;
      r_step <= r_step + SW'(1);
    end
  end

  // ------------------------------------------------ buffer write data
  logic [31:0]   w_ext;
  logic [BW-1:0] w_bin_flat;
  logic [BW-1:0] w_wr_nib;
  logic          w_wr_ovf;

  // Captured value zero-extended so hex nibbles above VAL_W read as 0.
  always_comb begin
    w_ext = '0;
    w_ext[VAL_W-1:0] = r_cap_value;
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bin
    assign w_bin_flat[4*gi +: 4] = {3'b000, w_ext[gi]};
  end

  // Select the digit image for the pending buffer write.
  always_comb begin
    w_wr_nib = w_ext[BW-1:0];
    w_wr_ovf = 1'b0;
    if (r_state == S_CONV) begin
      w_wr_nib = w_bcd_next;
      w_wr_ovf = w_ovf_next;
    end else if (r_cap_mode == MODE_BIN) begin
      w_wr_nib = w_bin_flat;
    end
  end

  // ------------------------------------------------------ display buffer
  logic [BW-1:0]     r_buf_nib;
  logic              r_buf_ovf;
  logic [DIGITS-1:0] r_buf_dp;
  logic [1:0]        r_buf_mode;
  logic              r_buf_lz;

  // Display buffer, replaced atomically so the scanner never sees a mix.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_buf_nib  <= '0;
      r_buf_ovf  <= 1'b0;
      r_buf_dp   <= '0;
      r_buf_mode <= MODE_HEX;
      r_buf_lz   <= 1'b0;
    end else if (w_buf_we) begin
      r_buf_nib  <= w_wr_nib;
      r_buf_ovf  <= w_wr_ovf;
      r_buf_dp   <= r_cap_dp;
      r_buf_mode <= r_cap_mode;
      r_buf_lz   <= r_cap_lz;
    end
  end

  // -------------------------------------------------- digit selection
  logic [3:0]        w_nib_arr [DIGITS];
  logic [DIGITS-1:0] w_show;
  logic [3:0]        w_cur_nib;
  logic              w_visible;
  logic [DIGITS-1:0] w_onehot;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign w_nib_arr[gi] = r_buf_nib[4*gi +: 4];
  end

  // A digit survives blanking if it or any digit above it is nonzero; digit 0 always does.
  always_comb begin
    logic v_any;
    v_any  = 1'b0;
    w_show = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (w_nib_arr[i] != 4'h0) v_any = 1'b1;
      w_show[i] = v_any | (i == 0);
    end
  end

  assign w_cur_nib = w_nib_arr[r_idx];
  assign w_onehot  = DIGITS'(1) << r_idx;
  assign w_visible = (r_buf_mode != MODE_BLANK) &&
                     (!r_buf_lz || (r_buf_mode == MODE_BIN) || r_buf_ovf || w_show[r_idx]);

  // ------------------------------------------------------------ outputs
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  // AN, SEG and DP change together, only on a tick, from the current buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_tick) begin
      if (w_visible) begin
        r_an  <= ~w_onehot;
        r_seg <= r_buf_ovf ? 7'h3F : f_glyph(w_cur_nib);
        r_dp  <= ~r_buf_dp[r_idx];
      end else begin
        r_an  <= '1;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign DP  = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 8 digits, 32-bit value, tick every 4 clocks.
module tb_seg_scan_driver;

  localparam int DIGITS  = 8;
  localparam int VAL_W   = 32;
  localparam int CLK_HZ  = 100;
  localparam int SCAN_HZ = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic [1:0]  mode;
  logic        lz_blank;
  logic [7:0]  dp;
  logic        load;
  logic        busy;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  logic [6:0] c_seg [8];
  logic       c_dpv [8];
  logic [7:0] c_seen;
  logic       c_busy;
  int         c_badan;

  always #5 clk = ~clk;

  // Edges since the last reset edge; a tick lands on every nonzero multiple of 4.
  always @(posedge clk) edge_n <= rst ? 0 : edge_n + 1;

  seg_scan_driver #(
    .DIGITS (DIGITS),
    .VAL_W  (VAL_W),
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .value   (value),
    .mode    (mode),
    .lz_blank(lz_blank),
    .dp      (dp),
    .load    (load),
    .busy    (busy),
    .AN      (an),
    .SEG     (seg),
    .DP      (dp_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record what each digit shows over n cycles.
  task automatic collect(input int n);
    c_seen  = '0;
    c_busy  = 1'b0;
    c_badan = 0;
    for (int i = 0; i < 8; i++) begin
      c_seg[i] = 7'h7F;
      c_dpv[i] = 1'b1;
    end
    repeat (n) begin
      @(negedge clk);
      if (busy) c_busy = 1'b1;
      if (an != 8'hFF) begin
        if ($countones(~an) != 1) c_badan++;
        else begin
          for (int i = 0; i < 8; i++) begin
            if (!an[i]) begin
              c_seen[i] = 1'b1;
              c_seg[i]  = seg;
              c_dpv[i]  = dp_n;
            end
          end
        end
      end
    end
  endtask

  // One-cycle load pulse; returns at the negedge after the accepting edge.
  task automatic load_val(input logic [31:0] v, input logic [1:0] m,
                          input logic lz, input logic [7:0] d);
    $display("load: value=%h mode=%b lz=%b dp=%h", v, m, lz, d);
    value    = v;
    mode     = m;
    lz_blank = lz;
    dp       = d;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] exp8;
    logic [6:0] exp_dec [8];
    logic [6:0] exp_bin [8];
    int cnt;

    exp_dec = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40};
    exp_bin = '{7'h40, 7'h79, 7'h40, 7'h40, 7'h79, 7'h79, 7'h40, 7'h79};

    rst = 1'b1; load = 1'b0; value = '0; mode = 2'b00; lz_blank = 1'b0; dp = '0;

    // Reset state and first refresh cycle.
    repeat (3) @(negedge clk);
    $display("step: reset");
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("pre_tick_an", 32'(an), 32'hFF);
    end
    @(negedge clk);
    check("first_tick_an", 32'(an), 32'hFE);
    check("first_tick_seg", 32'(seg), 32'h40);
    check("first_tick_dp", 32'(dp_n), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      repeat (4) @(negedge clk);
      exp8 = ~(8'h01 << (k % 8));
      check("walk_an", 32'(an), 32'(exp8));
      check("walk_seg", 32'(seg), 32'h40);
    end

    // Hex with leading-zero blanking.
    load_val(32'h0000_A5C3, 2'b01, 1'b1, 8'h00);
    check("hex_busy_after_load", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    collect(32);
    check("hex_busy_seen", 32'(c_busy), 32'd0);
    check("hex_seen", 32'(c_seen), 32'h0F);
    check("hex_seg0", 32'(c_seg[0]), 32'h30);
    check("hex_seg1", 32'(c_seg[1]), 32'h46);
    check("hex_seg2", 32'(c_seg[2]), 32'h12);
    check("hex_seg3", 32'(c_seg[3]), 32'h08);
    check("hex_dp0", 32'(c_dpv[0]), 32'd1);
    check("hex_onehot", 32'(c_badan), 32'd0);

    // Decimal 12345 with a load attempted mid-conversion.
    load_val(32'd12345, 2'b10, 1'b0, 8'h00);
    check("dec_busy_rise", 32'(busy), 32'd1);
    cnt = 1;
    while (busy && cnt < 100) begin
      if (cnt == 10) begin
        value = 32'd999; mode = 2'b01; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      if (busy) cnt++;
    end
    load = 1'b0;
    check("dec_busy_cycles", 32'(cnt), 32'd32);
    repeat (4) @(negedge clk);
    collect(32);
    check("dec_seen", 32'(c_seen), 32'hFF);
    for (int i = 0; i < 8; i++) check("dec_seg", 32'(c_seg[i]), 32'(exp_dec[i]));

    // Largest value that still fits in 8 digits.
    load_val(32'd99_999_999, 2'b10, 1'b0, 8'h00);
    wait_idle();
    repeat (4) @(negedge clk);
    collect(32);
    check("dec_max_seen", 32'(c_seen), 32'hFF);
    for (int i = 0; i < 8; i++) check("dec_max_seg", 32'(c_seg[i]), 32'h10);

    // Overflow: dashes everywhere, decimal point on digit 0 only.
    load_val(32'd100_000_000, 2'b10, 1'b0, 8'h01);
    wait_idle();
    repeat (4) @(negedge clk);
    collect(32);
    check("ovf_seen", 32'(c_seen), 32'hFF);
    for (int i = 0; i < 8; i++) check("ovf_seg", 32'(c_seg[i]), 32'h3F);
    check("ovf_dp0", 32'(c_dpv[0]), 32'd0);
    for (int i = 1; i < 8; i++) check("ovf_dp_other", 32'(c_dpv[i]), 32'd1);

    // Binary mode; lz_blank has no effect here.
    load_val(32'h0000_00B2, 2'b00, 1'b1, 8'h00);
    repeat (5) @(negedge clk);
    collect(32);
    check("bin_seen", 32'(c_seen), 32'hFF);
    for (int i = 0; i < 8; i++) check("bin_seg", 32'(c_seg[i]), 32'(exp_bin[i]));

    // Reset at conversion cycle 10, together with a load that must lose.
    load_val(32'd12345, 2'b10, 1'b0, 8'h00);
    cnt = 1;
    while (cnt < 10) begin
      @(negedge clk);
      if (busy) cnt++;
      else cnt = 100;
    end
    check("abort_reached_cycle10", 32'(cnt), 32'd10);
    $display("step: reset during conversion");
    rst = 1'b1; load = 1'b1; value = 32'h5; mode = 2'b01;
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an", 32'(an), 32'hFF);
    collect(36);
    check("abort_seen", 32'(c_seen), 32'hFF);
    for (int i = 0; i < 8; i++) check("abort_seg", 32'(c_seg[i]), 32'h40);

    // Buffer write landing on a tick edge.
    load_val(32'h1111_1111, 2'b01, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if ((edge_n + 2) % 4 == 0) break;
      @(negedge clk);
    end
    load_val(32'h2222_2222, 2'b01, 1'b0, 8'h00);
    @(negedge clk);
    check("coinc_old_glyph", 32'(seg), 32'h79);
    repeat (4) @(negedge clk);
    check("coinc_new_glyph", 32'(seg), 32'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
